// File: rtl/openram_tiled_pkg.sv
// Shared geometry helpers and timing constants for the tiled OpenRAM wrapper.
// A macro's dout0 is valid one clock after a selected read.
package openram_tiled_pkg;

  localparam int MACRO_RD_LAT = 1;

  function automatic int granule(input int data_w, input int mask_w);
    return (mask_w > 0) ? data_w / mask_w : 0;
  endfunction

  function automatic int n_row(input int addr_w, input int macro_addr_w);
    return (addr_w >= macro_addr_w) ? (1 << (addr_w - macro_addr_w)) : 1;
  endfunction

  function automatic int n_col(input int data_w, input int macro_data_w);
    return (macro_data_w > 0) ? data_w / macro_data_w : 0;
  endfunction

  function automatic bit cfg_ok(input int addr_w, input int data_w, input int mask_w,
                                input int macro_addr_w, input int macro_data_w,
                                input int macro_mask_w);
    return (mask_w > 0) && (macro_data_w > 0) && (macro_mask_w > 0) &&
           (data_w % macro_data_w == 0) && (addr_w >= macro_addr_w) &&
           (macro_data_w / macro_mask_w == granule(data_w, mask_w));
  endfunction

endpackage

// File: rtl/openram_macro.sv
// Behavioural stand-in for the generated OpenRAM 1RW macro (active-low csb0/web0).
// Read latency 1; dout0 keeps its last read value otherwise. Contents have no reset.
module openram_macro #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 64,
  parameter int MASK_W = 8
) (
  input  logic              clk0,
  input  logic              csb0,
  input  logic              web0,
  input  logic [MASK_W-1:0] wmask0,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [DATA_W-1:0] din0,
  output logic [DATA_W-1:0] dout0
);
  localparam int G = DATA_W / MASK_W;

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk0) begin
    if (!csb0) begin
      if (!web0) begin
        for (int i = 0; i < MASK_W; i++) begin
          if (wmask0[i]) mem[addr0][i*G +: G] <= din0[i*G +: G];
        end
      end else begin
        dout0 <= mem[addr0];
      end
    end
  end

endmodule

// File: rtl/openram_tiled_row.sv
// One row of N_COL macros sharing chip-select, write-enable and address;
// data and mask are sliced per column. Latency is that of the macro.
module openram_tiled_row
  import openram_tiled_pkg::*;
#(
  parameter int DATA_W       = 256,
  parameter int MASK_W       = 32,
  parameter int MACRO_ADDR_W = 7,
  parameter int MACRO_DATA_W = 64,
  parameter int MACRO_MASK_W = 8
) (
  input  logic                    clk,
  input  logic                    csb,
  input  logic                    web,
  input  logic [MACRO_ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0]       din,
  input  logic [MASK_W-1:0]       wmask,
  output logic [DATA_W-1:0]       dout
);
  localparam int N_COL = n_col(DATA_W, MACRO_DATA_W);

  for (genvar c = 0; c < N_COL; c++) begin : g_col
    openram_macro #(
      .ADDR_W(MACRO_ADDR_W),
      .DATA_W(MACRO_DATA_W),
      .MASK_W(MACRO_MASK_W)
    ) u_macro (
      .clk0  (clk),
      .csb0  (csb),
      .web0  (web),
      .wmask0(wmask[c*MACRO_MASK_W +: MACRO_MASK_W]),
      .addr0 (addr),
      .din0  (din[c*MACRO_DATA_W +: MACRO_DATA_W]),
      .dout0 (dout[c*MACRO_DATA_W +: MACRO_DATA_W])
    );
  end

endmodule

// File: rtl/openram_rw_tiled.sv
// RW0 memory port over an N_ROW x N_COL grid of OpenRAM macros; read latency 1, or 2
// with OPENRAM_TILED_OUTREG_EN. No backpressure: one access per cycle, rdata held between reads.
module openram_rw_tiled
  import openram_tiled_pkg::*;
#(
  parameter int ADDR_W       = 9,
  parameter int DATA_W       = 256,
  parameter int MASK_W       = 32,
  parameter int MACRO_ADDR_W = 7,
  parameter int MACRO_DATA_W = 64,
  parameter int MACRO_MASK_W = 8
) (
  input  logic              RW0_clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] RW0_addr,
  input  logic              RW0_en,
  input  logic              RW0_wmode,
  input  logic [DATA_W-1:0] RW0_wdata,
  input  logic [MASK_W-1:0] RW0_wmask,
  output logic [DATA_W-1:0] RW0_rdata,
  output logic              RW0_rvalid
);
  localparam int N_ROW = n_row(ADDR_W, MACRO_ADDR_W);
  localparam int ROW_W = (ADDR_W > MACRO_ADDR_W) ? ADDR_W - MACRO_ADDR_W : 1;

  if (!cfg_ok(ADDR_W, DATA_W, MASK_W, MACRO_ADDR_W, MACRO_DATA_W, MACRO_MASK_W)) begin : g_bad_cfg
    $error("openram_rw_tiled: macro geometry does not tile the RW0 port");
  end
  if (MACRO_RD_LAT != 1) begin : g_bad_lat
    $error("openram_rw_tiled: select/hold pipeline assumes a 1-cycle macro");
  end

  logic [ROW_W-1:0] row;
  if (ADDR_W > MACRO_ADDR_W) begin : g_row_idx
    assign row = RW0_addr[ADDR_W-1:MACRO_ADDR_W];
  end else begin : g_row_one
    assign row = '0;
  end

  logic [N_ROW-1:0]  row_csb;
  logic [DATA_W-1:0] row_dout [N_ROW];

  // Reset masks every chip-select so a colliding access never touches the array.
  always_comb begin
    row_csb = '1;
    for (int r = 0; r < N_ROW; r++) begin
      row_csb[r] = !(RW0_en && !reset && (int'(row) == r));
    end
  end

  for (genvar r = 0; r < N_ROW; r++) begin : g_row
    openram_tiled_row #(
      .DATA_W      (DATA_W),
      .MASK_W      (MASK_W),
      .MACRO_ADDR_W(MACRO_ADDR_W),
      .MACRO_DATA_W(MACRO_DATA_W),
      .MACRO_MASK_W(MACRO_MASK_W)
    ) u_row (
      .clk  (RW0_clk),
      .csb  (row_csb[r]),
      .web  (!RW0_wmode),
      .addr (RW0_addr[MACRO_ADDR_W-1:0]),
      .din  (RW0_wdata),
      .wmask(RW0_wmask),
      .dout (row_dout[r])
    );
  end

  logic             rd_q, rd_d;
  logic [ROW_W-1:0] sel_q, sel_d;
  logic [DATA_W-1:0] rd_mux;

  always_comb begin
    rd_d   = RW0_en && !RW0_wmode && !reset;
    sel_d  = rd_d ? row : sel_q;
    rd_mux = row_dout[sel_q];
  end

  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      rd_q  <= 1'b0;
      sel_q <= '0;
    end else begin
      rd_q  <= rd_d;
      sel_q <= sel_d;
    end
  end

`ifdef OPENRAM_TILED_OUTREG_EN
  logic              vld_q, vld_d;
  logic [DATA_W-1:0] out_q, out_d;

  always_comb begin
    vld_d = rd_q;
    out_d = rd_q ? rd_mux : out_q;
  end

  always_ff @(posedge RW0_clk) begin
    if (reset) begin
      vld_q <= 1'b0;
      out_q <= '0;
    end else begin
      vld_q <= vld_d;
      out_q <= out_d;
    end
  end

  assign RW0_rdata  = out_q;
  assign RW0_rvalid = vld_q;
`else
  logic [DATA_W-1:0] hold_q, hold_d;

  always_comb begin
    hold_d = rd_q ? rd_mux : hold_q;
  end

  always_ff @(posedge RW0_clk) begin
    if (reset) hold_q <= '0;
    else       hold_q <= hold_d;
  end

  assign RW0_rdata  = rd_q ? rd_mux : hold_q;
  assign RW0_rvalid = rd_q;
`endif

endmodule

// File: tb/tb_openram_rw_tiled.sv
// Bench for openram_rw_tiled: directed scenarios plus random traffic checked against
// a word-array memory model with a read-result pipeline of the configured latency.
module tb_openram_rw_tiled;
  localparam int AW = 9;
  localparam int DW = 256;
  localparam int MW = 32;
`ifdef OPENRAM_TILED_OUTREG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  typedef struct {
    logic          rst;
    logic          en;
    logic          wm;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [MW-1:0] m;
  } op_t;

  logic          RW0_clk = 1'b0;
  logic          reset = 1'b1;
  logic [AW-1:0] RW0_addr = '0;
  logic          RW0_en = 1'b0;
  logic          RW0_wmode = 1'b0;
  logic [DW-1:0] RW0_wdata = '0;
  logic [MW-1:0] RW0_wmask = '0;
  logic [DW-1:0] RW0_rdata;
  logic          RW0_rvalid;

  always #5 RW0_clk = ~RW0_clk;

  openram_rw_tiled dut (
    .RW0_clk   (RW0_clk),
    .reset     (reset),
    .RW0_addr  (RW0_addr),
    .RW0_en    (RW0_en),
    .RW0_wmode (RW0_wmode),
    .RW0_wdata (RW0_wdata),
    .RW0_wmask (RW0_wmask),
    .RW0_rdata (RW0_rdata),
    .RW0_rvalid(RW0_rvalid)
  );

  // Reference model: memory words, in-flight read values with their ages, last delivered value.
  logic [DW-1:0] mdl [2**AW];
  logic [DW-1:0] pend_val[$];
  int            pend_age[$];
  logic [DW-1:0] held = '0;
  logic          exp_vld = 1'b0;
  int            checks = 0;
  int            errors = 0;
  int            cyc = 0;

  function automatic op_t mk(input logic rst, input logic en, input logic wm,
                             input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [MW-1:0] m);
    op_t o;
    o.rst = rst; o.en = en; o.wm = wm; o.a = a; o.d = d; o.m = m;
    return o;
  endfunction

  function automatic logic [DW-1:0] rand_word();
    logic [DW-1:0] w;
    for (int i = 0; i < DW/32; i++) w[i*32 +: 32] = $urandom();
    return w;
  endfunction

  task automatic step(input op_t op);
    reset     = op.rst;
    RW0_en    = op.en;
    RW0_wmode = op.wm;
    RW0_addr  = op.a;
    RW0_wdata = op.d;
    RW0_wmask = op.m;
    @(posedge RW0_clk);
    #1;
    cyc++;
    if (op.rst) begin
      pend_val.delete();
      pend_age.delete();
      held    = '0;
      exp_vld = 1'b0;
    end else begin
      if (op.en && !op.wm) begin
        pend_val.push_back(mdl[op.a]);
        pend_age.push_back(0);
      end else if (op.en) begin
        for (int g = 0; g < MW; g++)
          if (op.m[g]) mdl[op.a][g*8 +: 8] = op.d[g*8 +: 8];
      end
      foreach (pend_age[i]) pend_age[i]++;
      exp_vld = 1'b0;
      if (pend_age.size() > 0 && pend_age[0] == LAT) begin
        held = pend_val.pop_front();
        void'(pend_age.pop_front());
        exp_vld = 1'b1;
      end
    end
  endtask

  task automatic test_reset();
    op_t ops[$];
    for (int i = 0; i < 3; i++) ops.push_back(mk(1, 0, 0, '0, '0, '0));
    for (int i = 0; i < 10; i++) ops.push_back(mk(0, 0, 0, AW'($urandom()), rand_word(), '1));
    foreach (ops[i]) begin
      step(ops[i]);
      checks++;
      if (RW0_rvalid !== 1'b0 || RW0_rdata !== '0) begin
        errors++;
        $display("FAIL reset_idle cyc=%0d rvalid=%0b want 0 rdata=%h want 0", cyc, RW0_rvalid, RW0_rdata);
      end
    end
  endtask

  task automatic test_fill();
    op_t ops[$];
    for (int a = 0; a < 2**AW; a++) ops.push_back(mk(0, 1, 1, AW'(a), rand_word(), '1));
    foreach (ops[i]) begin
      step(ops[i]);
      checks++;
      if (RW0_rvalid !== exp_vld || RW0_rdata !== held) begin
        errors++;
        $display("FAIL fill cyc=%0d rvalid=%0b exp %0b rdata=%h exp %h", cyc, RW0_rvalid, exp_vld, RW0_rdata, held);
      end
    end
  endtask

  task automatic test_patterns();
    op_t ops[$];
    logic [DW-1:0] pat_a = {8{32'hDEADBEEF}};
    logic [DW-1:0] pat_b = {8{32'h0BADF00D}};
    ops.push_back(mk(0, 1, 1, 9'h005, pat_a, '1));
    ops.push_back(mk(0, 1, 1, 9'h185, pat_b, '1));
    ops.push_back(mk(0, 1, 0, 9'h005, '0, '0));
    ops.push_back(mk(0, 1, 0, 9'h185, '0, '0));
    for (int i = 0; i < 3; i++) ops.push_back(mk(0, 0, 0, '0, '0, '0));
    foreach (ops[i]) begin
      step(ops[i]);
      checks++;
      if (RW0_rvalid !== exp_vld || RW0_rdata !== held) begin
        errors++;
        $display("FAIL patterns cyc=%0d rvalid=%0b exp %0b rdata=%h exp %h", cyc, RW0_rvalid, exp_vld, RW0_rdata, held);
      end
      if (i == 1 + LAT || i == 2 + LAT) begin
        checks++;
        if (RW0_rvalid !== 1'b1 || RW0_rdata !== ((i == 1 + LAT) ? pat_a : pat_b)) begin
          errors++;
          $display("FAIL pattern_value step=%0d rvalid=%0b rdata=%h", i, RW0_rvalid, RW0_rdata);
        end
      end
    end
  endtask

  task automatic test_mask();
    op_t ops[$];
    logic [DW-1:0] want = {{(DW-8){1'b1}}, 8'h00};
    ops.push_back(mk(0, 1, 1, 9'h0A0, '1, '1));
    ops.push_back(mk(0, 1, 1, 9'h0A0, '0, 32'h0000_0001));
    ops.push_back(mk(0, 1, 1, 9'h0A0, '0, '0));
    ops.push_back(mk(0, 1, 0, 9'h0A0, '0, '0));
    for (int i = 0; i < 3; i++) ops.push_back(mk(0, 0, 0, '0, '0, '0));
    foreach (ops[i]) begin
      step(ops[i]);
      checks++;
      if (RW0_rvalid !== exp_vld || RW0_rdata !== held) begin
        errors++;
        $display("FAIL mask cyc=%0d rvalid=%0b exp %0b rdata=%h exp %h", cyc, RW0_rvalid, exp_vld, RW0_rdata, held);
      end
    end
    checks++;
    if (RW0_rdata !== want) begin
      errors++;
      $display("FAIL mask_value rdata=%h want %h", RW0_rdata, want);
    end
  endtask

  task automatic test_back_to_back();
    op_t ops[$];
    int pulses = 0;
    ops.push_back(mk(0, 1, 0, 9'h010, '0, '0));
    ops.push_back(mk(0, 1, 0, 9'h090, '0, '0));
    ops.push_back(mk(0, 1, 0, 9'h110, '0, '0));
    for (int i = 0; i < 4; i++) ops.push_back(mk(0, 0, 0, '0, '0, '0));
    foreach (ops[i]) begin
      step(ops[i]);
      if (RW0_rvalid === 1'b1) pulses++;
      checks++;
      if (RW0_rvalid !== exp_vld || RW0_rdata !== held) begin
        errors++;
        $display("FAIL back_to_back cyc=%0d rvalid=%0b exp %0b rdata=%h exp %h", cyc, RW0_rvalid, exp_vld, RW0_rdata, held);
      end
    end
    checks++;
    if (pulses != 3) begin
      errors++;
      $display("FAIL b2b_pulses got %0d want 3", pulses);
    end
  endtask

  task automatic test_hold();
    op_t ops[$];
    logic [DW-1:0] first = mdl[9'h010];
    ops.push_back(mk(0, 1, 0, 9'h010, '0, '0));
    for (int i = 0; i < 5; i++)
      ops.push_back(mk(0, 0, 1'($urandom()), AW'($urandom()), rand_word(), MW'($urandom())));
    ops.push_back(mk(0, 1, 1, 9'h010, rand_word(), '1));
    for (int i = 0; i < 3; i++) ops.push_back(mk(0, 0, 0, '0, '0, '0));
    foreach (ops[i]) begin
      step(ops[i]);
      checks++;
      if (RW0_rvalid !== exp_vld || RW0_rdata !== held) begin
        errors++;
        $display("FAIL hold cyc=%0d rvalid=%0b exp %0b rdata=%h exp %h", cyc, RW0_rvalid, exp_vld, RW0_rdata, held);
      end
    end
    checks++;
    if (RW0_rdata !== first) begin
      errors++;
      $display("FAIL hold_value rdata=%h want %h", RW0_rdata, first);
    end
  endtask

  task automatic test_reset_collisions();
    op_t ops[$];
    ops.push_back(mk(1, 1, 0, 9'h010, '0, '0));
    ops.push_back(mk(0, 0, 0, '0, '0, '0));
    ops.push_back(mk(1, 1, 1, 9'h033, rand_word(), '1));
    ops.push_back(mk(0, 1, 0, 9'h010, '0, '0));
    ops.push_back(mk(0, 1, 0, 9'h033, '0, '0));
    for (int i = 0; i < 3; i++) ops.push_back(mk(0, 0, 0, '0, '0, '0));
    ops.push_back(mk(0, 1, 0, 9'h110, '0, '0));
    ops.push_back(mk(1, 0, 0, '0, '0, '0));
    ops.push_back(mk(0, 0, 0, '0, '0, '0));
    ops.push_back(mk(0, 0, 0, '0, '0, '0));
    foreach (ops[i]) begin
      step(ops[i]);
      checks++;
      if (RW0_rvalid !== exp_vld || RW0_rdata !== held) begin
        errors++;
        $display("FAIL reset_collide cyc=%0d rvalid=%0b exp %0b rdata=%h exp %h", cyc, RW0_rvalid, exp_vld, RW0_rdata, held);
      end
    end
  endtask

  task automatic test_random();
    op_t ops[$];
    for (int i = 0; i < 400; i++) begin
      logic [MW-1:0] m;
      int sel = $urandom_range(0, 9);
      m = (sel == 0) ? '0 : (sel < 5) ? '1 : MW'($urandom());
      ops.push_back(mk(($urandom_range(0, 39) == 0), ($urandom_range(0, 9) < 7),
                       1'($urandom()), AW'($urandom()), rand_word(), m));
    end
    foreach (ops[i]) begin
      step(ops[i]);
      checks++;
      if (RW0_rvalid !== exp_vld || RW0_rdata !== held) begin
        errors++;
        $display("FAIL random cyc=%0d rvalid=%0b exp %0b rdata=%h exp %h", cyc, RW0_rvalid, exp_vld, RW0_rdata, held);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_patterns();
    test_mask();
    test_back_to_back();
    test_hold();
    test_reset_collisions();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/openram_rw_tiled.md
Name: openram_rw_tiled

Overview:
- Parametrised single-port read/write memory wrapper; successor to the fixed per-memory OpenRAM wrappers.
- Presents the standard RW0 memory port to the generated design.
- Tiles a fixed-size OpenRAM macro in depth (rows) and width (columns). Only the addressed row of macros is selected.
- Registers the row select so read data is muxed correctly one cycle later, and holds read data stable between reads.

Parameters:
- ADDR_W, 9, RW0 address width; depth = 2^ADDR_W.
- DATA_W, 256, RW0 data width.
- MASK_W, 32, RW0 write-mask width; granule G = DATA_W/MASK_W.
- MACRO_ADDR_W, 7, macro address width (128 rows per macro).
- MACRO_DATA_W, 64, macro data width.
- MACRO_MASK_W, 8, macro mask width.
- Derived: N_ROW = 2^(ADDR_W-MACRO_ADDR_W) and N_COL = DATA_W/MACRO_DATA_W.
- Elaboration error unless:
  - DATA_W % MACRO_DATA_W == 0;
  - ADDR_W >= MACRO_ADDR_W;
  - MACRO_DATA_W/MACRO_MASK_W == G.

Ports:
- Interface (already decided): one clock, RW0_clk; reset is synchronous and active-high, port reset.
- RW0_clk  in  1  clock.
- reset  in  1  synchronous active-high reset.
- RW0_addr  in  ADDR_W  word address.
- RW0_en  in  1  access enable.
- RW0_wmode  in  1  1=write, 0=read (valid with RW0_en).
- RW0_wdata  in  DATA_W  write data.
- RW0_wmask  in  MASK_W  per-granule write enable.
- RW0_rdata  out  DATA_W  read data.
- RW0_rvalid  out  1  pulses when RW0_rdata carries fresh read data.

Behaviour:
- Address split: row = RW0_addr[ADDR_W-1:MACRO_ADDR_W]; macro address = RW0_addr[MACRO_ADDR_W-1:0].
- Macro (r,c) controls:
  - csb0 = !(RW0_en && !reset && row==r); all rows are deselected during reset.
  - web0 = !RW0_wmode.
  - din0 = RW0_wdata[c*MACRO_DATA_W +: MACRO_DATA_W].
  - wmask0 = RW0_wmask[c*MACRO_MASK_W +: MACRO_MASK_W].
- Registers, updated on RW0_clk:
  - rd_q <= RW0_en && !RW0_wmode && !reset.
  - sel_q <= row, loaded only on a read.
  - hold_q <= RW0_rdata, loaded every cycle rd_q==1.
- Read latency 1. RW0_rdata = rd_q ? {row sel_q of macro dout0, columns concatenated} : hold_q.
- RW0_rvalid = rd_q.
- Reset values: rd_q=0, sel_q=0, hold_q=0, so RW0_rdata=0 and RW0_rvalid=0.
- Write: RW0_rdata is unchanged (hold). A write to the address just read does not alter the held value.
- Back-to-back reads to different rows: each result comes from its own registered row; no bubble.
- Read then write next cycle: the read result is presented during the write cycle, then held.
- RW0_en=0 with other inputs toggling: no macro selected, outputs held.
- Reset asserted in the same cycle as a read: the read is squashed (no csb, rvalid stays 0).
- Reset asserted the cycle after a read: rd_q is cleared at that clock edge; the data is lost and RW0_rdata=0.
- Memory contents are not cleared by reset.
- All-zero mask write: macro selected, no bits change.

Optional Feature:
- OPENRAM_TILED_OUTREG_EN defined:
  - adds an output register stage; RW0_rdata is driven from a flop, read latency 2;
  - RW0_rvalid asserts two cycles after the read;
  - the output flop resets to 0 and holds when no read completes.
- Undefined: latency 1 as above; RW0_rdata is a combinational mux of macro outputs.

Decomposition:
- Package openram_tiled_pkg holds:
  - G and the row/column count functions;
  - the elaboration-check function;
  - the macro timing constant (read latency 1).
- One sub-module, openram_tiled_row: one row of N_COL macros, with shared csb/web and sliced din/wmask/dout.
  - The top instantiates N_ROW rows and owns the select/hold/valid logic.
- The macro itself is the external openram black box; the bench binds a behavioural model.

Test Plan:
- Reset, then idle -> RW0_rdata=0 and RW0_rvalid=0 for 10 cycles; no csb0 asserted during reset.
- Write 0x...DEADBEEF pattern (full mask) to addr 0x005 and to 0x185 (row 3) -> read 0x005 returns pattern A and 0x185 returns pattern B, one cycle later, with rvalid=1 each.
- Write all-ones to addr 0x0A0, then write zeros with wmask=0x0000_0001 -> read returns all-ones except bits [7:0]=0.
- Back-to-back reads at 0x010 (row 0), 0x090 (row 1), 0x110 (row 2) -> three consecutive rvalid pulses with the correct data in order.
- Read 0x010, then hold RW0_en=0 for 5 cycles while toggling addr/wdata, then write 0x010 -> RW0_rdata stays at the first read value throughout.
- Assert reset in the same cycle as a read of 0x010 -> no rvalid, RW0_rdata=0, macro contents preserved on a later read.
- With OPENRAM_TILED_OUTREG_EN defined, rerun the above -> every rvalid and data shifted by one more cycle.
